instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Upstream program loader for the 256x16 instruction memory. Accepts a byte stream (valid/ready),
//  assembles big-endian 16-bit words, writes them to consecutive addresses from 0 using the memory's
//  instruction_in / instruction_add / write_enable inputs, then signals done.
//  The top level muxes these outputs with the PC while busy=1.
// PARAMETERS
//  DATA_W   16   instruction word width (must equal 2*BYTE_W)
//  BYTE_W   8    stream byte width
//  ADDR_W   8    instruction address width; depth = 2**ADDR_W = 256
// PORTS
//  clk              in   1         single clock, all logic on posedge
//  reset            in   1         synchronous, active-high
//  start            in   1         begin load; sampled only in IDLE
//  load_len         in   ADDR_W+1  number of words to load, latched on accepted start (valid 1..256)
//  byte_in          in   BYTE_W    stream data
//  byte_valid       in   1         stream data valid
//  byte_ready       out  1         loader accepts byte_in this cycle (transfer = valid & ready)
//  instruction_in   out  DATA_W    word to memory
//  instruction_add  out  ADDR_W    write address to memory
//  write_enable     out  1         one-cycle memory write strobe
//  busy             out  1         loader owns the memory port (any state except IDLE)
//  done             out  1         one-cycle pulse at end of load
//  len_err          out  1         sticky until next accepted start: load_len was 0 or >256
//  checksum_err     out  1         sticky until next accepted start: checksum mismatch (tied 0 without macro)
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0: byte_ready, write_enable, busy, done, len_err, checksum_err,
//    instruction_in, instruction_add. Internal word count and address are cleared.
//  - FSM states: IDLE, HI, LO, WR, DONE (plus CK_HI, CK_LO with macro).
//  - IDLE: start=1 latches load_len, clears len_err/checksum_err/sum, addr=0, cnt=0.
//    - Valid length: -> HI.
//    - load_len==0 or >256: set len_err, -> DONE; no writes.
//  - HI: byte_ready=1; on transfer, instruction_in[15:8]=byte_in, -> LO.
//  - LO: byte_ready=1; on transfer, instruction_in[7:0]=byte_in, -> WR.
//  - WR: write_enable=1 for exactly one cycle, instruction_add=addr. Next cycle: addr+1 (wraps 255->0
//    only after word 256), cnt+1.
//    - cnt+1==len: -> DONE, or -> CK_HI with macro.
//    - Otherwise -> HI.
//  - Timing: the write strobe is the cycle after the low byte is accepted. Peak rate is one word per 3 cycles.
//  - DONE: done=1 for one cycle, busy=1, then -> IDLE.
//  - byte_ready is 0 in IDLE, WR and DONE. Bytes offered then are held off, never dropped.
//  - start outside IDLE is ignored. reset wins over any simultaneous start or transfer.
//  - Reset mid-load: -> IDLE immediately, write_enable deasserts that cycle. Already-written words
//    stay in memory. No done pulse.
//  - instruction_in and instruction_add hold their last values in IDLE.
// CONFIGURATION
//  - LOADER_CHECKSUM_EN defined:
//    - A 16-bit running sum (mod 2^16) of all written words is kept.
//    - After the last WR, CK_HI and CK_LO take 2 more bytes (big-endian expected sum).
//    - Mismatch sets checksum_err. -> DONE either way.
//  - LOADER_CHECKSUM_EN undefined: no sum register, no CK states, checksum_err tied 0.
// STRUCTURE
//  - Shared package proc_defs_pkg holds INSTR_W=16, IADDR_W=8, IMEM_DEPTH=256 and the loader state
//    encoding localparams (IDLE..CK_LO).
//  - No sub-module is needed. Byte assembly, counter and FSM go in one always block plus output
//    assigns.
// TESTING
//  1. load_len=3, bytes 12 34 AB CD 00 01 with valid held high -> writes 0x1234@0, 0xABCD@1, 0x0001@2.
//     Each write_enable is 1 cycle, 3 cycles apart. done pulses 1 cycle after the third write.
//     Memory readback matches.
//  2. load_len=0 -> no write_enable, len_err=1, done pulse 1 cycle after start. load_len=257 gives
//     the same result.
//  3. load_len=256 with random bytes -> 256 writes, addresses 0..255, last address 255, single done.
//  4. Random byte_valid gaps and start pulses while busy -> words unchanged, no duplicate or lost
//     bytes, start ignored.
//  5. reset asserted in LO of word 5 of 10 -> next cycle busy=0, write_enable=0, no done.
//     A new start then reloads from address 0.
//  6. (LOADER_CHECKSUM_EN) words 0x0001, 0xFFFF, then checksum bytes 00 00 -> checksum_err=0.
//     Checksum bytes 00 01 -> checksum_err=1. done pulses in both cases.

Source files
------------

// File: rtl/proc_defs_pkg.sv
// proc_defs_pkg: shared processor widths and the instruction-loader state encoding.
package proc_defs_pkg;
    localparam int INSTR_W    = 16;
    localparam int IADDR_W    = 8;
    localparam int IMEM_DEPTH = 256;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HI    = 3'd1;
    localparam logic [2:0] S_LO    = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_CK_HI = 3'd5;
    localparam logic [2:0] S_CK_LO = 3'd6;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        HI    = S_HI,
        LO    = S_LO,
        WR    = S_WR,
        DONE  = S_DONE,
        CK_HI = S_CK_HI,
        CK_LO = S_CK_LO
    } loader_state_t;
endpackage

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: assembles a big-endian byte stream into words written to instruction memory from address 0.
// LOADER_CHECKSUM_EN: two trailing bytes carry the expected 16-bit sum of the written words.
module instr_mem_loader
    import proc_defs_pkg::*;
#(
    parameter int DATA_W = INSTR_W,
    parameter int BYTE_W = 8,
    parameter int ADDR_W = IADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [DATA_W-1:0] instruction_in,
    output logic [ADDR_W-1:0] instruction_add,
    output logic              write_enable,
    output logic              busy,
    output logic              done,
    output logic              len_err,
    output logic              checksum_err
);
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(2**ADDR_W);

    loader_state_t     state;
    logic [ADDR_W:0]   len, cnt;
    logic [ADDR_W-1:0] addr;
    logic              xfer, bad_len, last;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic [BYTE_W-1:0] ck_hi;
`else
    assign checksum_err = 1'b0;
`endif

    assign xfer         = byte_valid && byte_ready;
    assign bad_len      = load_len == '0 || load_len > MAX_LEN;
    assign last         = cnt + (ADDR_W+1)'(1) == len;
    assign byte_ready   = state == HI || state == LO || state == CK_HI || state == CK_LO;
    assign write_enable = state == WR;
    assign busy         = state != IDLE;
    assign done         = state == DONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            len             <= '0;
            cnt             <= '0;
            addr            <= '0;
            instruction_in  <= '0;
            instruction_add <= '0;
            len_err         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum             <= '0;
            ck_hi           <= '0;
            checksum_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    len     <= load_len;
                    cnt     <= '0;
                    addr    <= '0;
                    len_err <= bad_len;
                    state   <= bad_len ? DONE : HI;
`ifdef LOADER_CHECKSUM_EN
                    sum          <= '0;
                    checksum_err <= 1'b0;
`endif
                end
                HI: if (xfer) begin
                    instruction_in[DATA_W-1 -: BYTE_W] <= byte_in;
                    state <= LO;
                end
                LO: if (xfer) begin
                    instruction_in[BYTE_W-1:0] <= byte_in;
                    instruction_add <= addr;
                    state <= WR;
                end
                WR: begin
                    addr <= addr + ADDR_W'(1);
                    cnt  <= cnt + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
                    sum   <= sum + instruction_in;
                    state <= last ? CK_HI : HI;
`else
                    state <= last ? DONE : HI;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                CK_HI: if (xfer) begin
                    ck_hi <= byte_in;
                    state <= CK_LO;
                end
                CK_LO: if (xfer) begin
                    checksum_err <= {ck_hi, byte_in} != sum;
                    state <= DONE;
                end
`endif
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed bench for instr_mem_loader with a 256x16 memory model and a byte-stream feeder.
module tb_instr_mem_loader;
    import proc_defs_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  load_len = '0;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] instruction_in;
    logic [7:0]  instruction_add;
    logic        write_enable, busy, done, len_err, checksum_err;

    instr_mem_loader dut (
        .clk(clk), .reset(reset), .start(start), .load_len(load_len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .instruction_in(instruction_in), .instruction_add(instruction_add),
        .write_enable(write_enable), .busy(busy), .done(done),
        .len_err(len_err), .checksum_err(checksum_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // memory model and event log, sampled on the write edge like the real memory
    logic [15:0] mem [0:IMEM_DEPTH-1];
    int          wr_addr[$];
    int          wr_cyc[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (write_enable) begin
            mem[instruction_add] = instruction_in;
            wr_addr.push_back(int'(instruction_add));
            wr_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (start) start_cyc = cyc;
    end

    // byte stream: main process appends, feeder consumes on accepted transfers
    logic [7:0] stream [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         gap_pct = 0;

    initial begin
        byte_valid = 1'b0;
        byte_in = '0;
        forever begin
            @(negedge clk);
            byte_valid = (rd_ptr != wr_ptr) && ($urandom_range(99) >= gap_pct);
            byte_in = stream[rd_ptr];
            @(posedge clk);
            if (byte_valid && byte_ready && !reset) rd_ptr++;
        end
    end

    task automatic push_word(input logic [15:0] w);
        stream[wr_ptr] = w[15:8];
        stream[wr_ptr+1] = w[7:0];
        wr_ptr += 2;
    endtask

    task automatic start_load(input logic [8:0] len);
        @(negedge clk);
        start = 1'b1;
        load_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int base;
        base = done_cnt;
        for (int k = 0; k < budget && done_cnt == base; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check(tag, done_cnt - base, 1);
    endtask

    logic [15:0] exp_w [0:255];
    int b;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", byte_ready, 0);
        check("rst_we", write_enable, 0);
        check("rst_done", done, 0);
        check("rst_len_err", len_err, 0);
        check("rst_ck_err", checksum_err, 0);
        check("rst_instr", instruction_in, 0);
        check("rst_addr", instruction_add, 0);
        reset = 1'b0;

        // zero and oversize lengths: error, immediate done, no writes
        b = wr_addr.size();
        start_load(9'd0);
        wait_done(20, "t2_len0_done");
        check("t2_len0_writes", wr_addr.size() - b, 0);
        check("t2_len0_err", len_err, 1);
        check("t2_len0_latency", done_cyc - start_cyc, 1);
        start_load(9'd257);
        wait_done(20, "t2_len257_done");
        check("t2_len257_writes", wr_addr.size() - b, 0);
        check("t2_len257_err", len_err, 1);
        check("t2_len257_latency", done_cyc - start_cyc, 1);

        // three words, valid held high
        b = wr_addr.size();
        push_word(16'h1234);
        push_word(16'hABCD);
        push_word(16'h0001);
        start_load(9'd3);
        check("t1_len_err_cleared", len_err, 0);
        wait_done(100, "t1_done");
        check("t1_writes", wr_addr.size() - b, 3);
        check("t1_mem0", mem[0], 16'h1234);
        check("t1_mem1", mem[1], 16'hABCD);
        check("t1_mem2", mem[2], 16'h0001);
        if (wr_addr.size() - b == 3) begin
            check("t1_addr0", wr_addr[b], 0);
            check("t1_addr2", wr_addr[b+2], 2);
            check("t1_gap01", wr_cyc[b+1] - wr_cyc[b], 3);
            check("t1_gap12", wr_cyc[b+2] - wr_cyc[b+1], 3);
            check("t1_done_lat", done_cyc - wr_cyc[b+2], 1);
        end
        check("t1_hold_add", instruction_add, 8'd2);
        check("t1_hold_in", instruction_in, 16'h0001);
        check("t1_idle", {busy, byte_ready, write_enable}, 3'b000);

        // full depth with random data
        b = wr_addr.size();
        for (int i = 0; i < 256; i++) begin
            exp_w[i] = 16'($urandom);
            push_word(exp_w[i]);
        end
        start_load(9'd256);
        wait_done(2000, "t3_done");
        check("t3_writes", wr_addr.size() - b, 256);
        for (int i = 0; i < 256 && i < wr_addr.size() - b; i++) begin
            check($sformatf("t3_mem%0d", i), mem[i], exp_w[i]);
            check($sformatf("t3_addr%0d", i), wr_addr[b+i], i);
        end
        check("t3_last_add", instruction_add, 8'd255);
        check("t3_len_err", len_err, 0);

        // valid gaps plus start pulses while busy
        b = wr_addr.size();
        gap_pct = 50;
        for (int i = 0; i < 8; i++) begin
            exp_w[i] = 16'h1000 + 16'(i) * 16'h0203;
            push_word(exp_w[i]);
        end
        start_load(9'd8);
        fork
            wait_done(2000, "t4_done");
            for (int k = 0; k < 6; k++) begin
                repeat ($urandom_range(3, 9)) @(negedge clk);
                if (busy) begin
                    start = 1'b1;
                    load_len = 9'd2;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        join
        repeat (10) @(negedge clk);
        gap_pct = 0;
        check("t4_writes", wr_addr.size() - b, 8);
        for (int i = 0; i < 8; i++) check($sformatf("t4_mem%0d", i), mem[i], exp_w[i]);
        check("t4_all_consumed", wr_ptr - rd_ptr, 0);
        check("t4_idle", busy, 0);

        // reset while the low byte of word 5 is pending
        b = wr_addr.size();
        for (int i = 0; i < 10; i++) push_word(16'h5000 + 16'(i));
        start_load(9'd10);
        begin
            int base_done;
            base_done = done_cnt;
            for (int k = 0; k < 200 && wr_addr.size() - b < 4; k++) @(negedge clk);
            check("t5_four_writes", wr_addr.size() - b, 4);
            @(posedge clk);
            @(negedge clk);
            check("t5_in_lo", {byte_ready, write_enable}, 2'b10);
            reset = 1'b1;
            wr_ptr = rd_ptr;
            @(negedge clk);
            check("t5_busy", busy, 0);
            check("t5_we", write_enable, 0);
            check("t5_ready", byte_ready, 0);
            reset = 1'b0;
            repeat (6) @(negedge clk);
            check("t5_no_more_writes", wr_addr.size() - b, 4);
            check("t5_no_done", done_cnt - base_done, 0);
        end
        b = wr_addr.size();
        push_word(16'hC0DE);
        push_word(16'hBEEF);
        push_word(16'h0042);
        start_load(9'd3);
        wait_done(100, "t5_reload_done");
        check("t5_reload_writes", wr_addr.size() - b, 3);
        if (wr_addr.size() - b == 3) check("t5_reload_addr0", wr_addr[b], 0);
        check("t5_reload_mem0", mem[0], 16'hC0DE);
        check("t5_reload_mem2", mem[2], 16'h0042);
        check("t5_kept_mem3", mem[3], 16'h5003);

`ifdef LOADER_CHECKSUM_EN
        push_word(16'h0001);
        push_word(16'hFFFF);
        push_word(16'h0000);
        start_load(9'd2);
        wait_done(100, "t6_good_done");
        check("t6_good_err", checksum_err, 0);
        check("t6_good_mem1", mem[1], 16'hFFFF);
        push_word(16'h0001);
        push_word(16'hFFFF);
        push_word(16'h0001);
        start_load(9'd2);
        wait_done(100, "t6_bad_done");
        check("t6_bad_err", checksum_err, 1);
        check("t6_consumed", wr_ptr - rd_ptr, 0);
`else
        check("t6_ck_tied", checksum_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
